// File: rtl/freq_div_ctrl.sv
// Run-time controller for the programmable clock divider: accepts divide ratios
// over valid/ready and swaps them in only at output-period boundaries.
module freq_div_ctrl #(
  parameter int W       = 16,
  parameter int DEF_DIV = 25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  input  logic         div_valid_i,
  output logic         div_ready_o,
  output logic         clk_o,
  output logic         tick_o,
  output logic         busy_o,
  output logic         err_o,
  output logic [W-1:0] cur_div_o
);

  // state    | meaning
  // ST_STOP  | idle, clk_o held low, counter cleared; pending ratio applied at once
  // ST_RUN   | generating clk_o
  // ST_DRAIN | stop requested, finishing the current period before going idle
  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] cur_div;
  logic [W-1:0] pend_val;
  logic         pend;
  logic         clk_q;
  logic         tick_q;
  logic         err_q;

  logic running;
  logic term;
  logic pe;
  logic xfer;

  assign running = (state != ST_STOP);
  assign term    = (cnt == cur_div - W'(1));
  assign pe      = running && term && clk_q;
  assign xfer    = div_valid_i && !pend;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP:  if (en_i) state_nxt = ST_RUN;
      ST_RUN:   if (!en_i) state_nxt = pe ? ST_STOP : ST_DRAIN;
      ST_DRAIN: begin
        if (en_i)    state_nxt = ST_RUN;
        else if (pe) state_nxt = ST_STOP;
      end
      default:  state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_STOP;
      cnt      <= '0;
      cur_div  <= W'(DEF_DIV);
      pend_val <= '0;
      pend     <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= xfer && (div_i == '0);

      // Leaving RUN/DRAIN only happens at PE, where the toggle already lands clk_q at 0.
      if (running) begin
        if (term) begin
          cnt    <= '0;
          clk_q  <= !clk_q;
          tick_q <= !clk_q;
        end else begin
          cnt    <= cnt + W'(1);
          tick_q <= 1'b0;
        end
      end else begin
        cnt    <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end

      // A transfer is only possible with pend clear, so it never collides with an apply.
      if (xfer && (div_i != '0)) begin
        pend     <= 1'b1;
        pend_val <= div_i;
      end else if (pend && (!running || pe)) begin
        cur_div <= pend_val;
        pend    <= 1'b0;
      end
    end
  end

  assign div_ready_o = !pend;
  assign clk_o       = clk_q;
  assign tick_o      = tick_q;
  assign busy_o      = running;
  assign err_o       = err_q;
  assign cur_div_o   = cur_div;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: expected tick-to-tick periods and high-phase
// lengths are queued as stimulus is applied and consumed as the divided clock runs.
module tb_freq_div_ctrl;

  localparam int W = 16;
  localparam int DEF_DIV = 25;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         en_i = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         div_valid_i = 1'b0;
  logic         div_ready_o;
  logic         clk_o;
  logic         tick_o;
  logic         busy_o;
  logic         err_o;
  logic [W-1:0] cur_div_o;

  freq_div_ctrl #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .cur_div_o   (cur_div_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int ticks = 0;
  int last_tick = 0;
  bit prev_ok = 0;
  int hi_len = 0;
  logic clk_prev = 1'b0;
  int exp_per[$];
  int exp_hi[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: consume expectations as the divided clock produces edges.
  task automatic observe();
    if (clk_o !== clk_prev || tick_o)
      chk("tick_align", {31'd0, tick_o}, {31'd0, clk_o && !clk_prev});
    if (tick_o) begin
      if (prev_ok && exp_per.size() > 0) chk("period", cyc_n - last_tick, exp_per.pop_front());
      last_tick = cyc_n;
      prev_ok = 1;
      ticks++;
    end
    if (clk_o) hi_len++;
    else if (hi_len > 0) begin
      if (exp_hi.size() > 0) chk("high_phase", hi_len, exp_hi.pop_front());
      hi_len = 0;
    end
    if (!busy_o) prev_ok = 0;
    clk_prev = clk_o;
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc_n++;
    observe();
  endtask

  task automatic wait_ticks(input int target, input int budget);
    for (int i = 0; i < budget && ticks < target; i++) step();
    if (ticks < target) chk("tick_timeout", ticks, target);
  endtask

  int base;
  int n;

  initial begin
    // Reset
    rst_i = 1'b0;
    repeat (3) step();
    chk("rst_clk", clk_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", div_ready_o, 1);
    chk("rst_cur_div", cur_div_o, DEF_DIV);
    chk("rst_err", err_o, 0);
    rst_i = 1'b1;
    step();

    // Load 3 while stopped, then run: 3 low / 3 high
    div_i = 3; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    chk("stop_ready_low", div_ready_o, 0);
    step();
    chk("stop_apply", cur_div_o, 3);
    chk("stop_ready_back", div_ready_o, 1);
    exp_per.push_back(6); exp_per.push_back(6); exp_per.push_back(6);
    exp_hi.push_back(3); exp_hi.push_back(3); exp_hi.push_back(3);
    en_i = 1'b1;
    base = ticks;
    wait_ticks(base + 4, 60);
    chk("run_busy", busy_o, 1);

    // Retarget to 5 in the first high cycle; old high phase must complete
    exp_hi.push_back(3); exp_hi.push_back(5); exp_hi.push_back(5);
    exp_per.push_back(8); exp_per.push_back(10); exp_per.push_back(10);
    base = ticks;
    div_i = 5; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    chk("pend_ready_low", div_ready_o, 0);
    n = 0;
    for (int i = 0; i < 20 && cur_div_o != 5; i++) begin step(); n++; end
    chk("apply_latency", n, 2);
    chk("apply_clk_low", clk_o, 0);
    chk("apply_ready", div_ready_o, 1);
    wait_ticks(base + 3, 60);

    // Zero ratio rejected
    exp_hi.push_back(5); exp_hi.push_back(5);
    exp_per.push_back(10); exp_per.push_back(10);
    base = ticks;
    div_i = 0; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    chk("err_pulse", err_o, 1);
    chk("err_ready", div_ready_o, 1);
    step();
    chk("err_clear", err_o, 0);
    chk("err_cur_div", cur_div_o, 5);
    wait_ticks(base + 2, 60);

    // Switch to 4, then drop en_i in the first high cycle
    exp_hi.push_back(5);
    exp_per.push_back(9);
    base = ticks;
    div_i = 4; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    wait_ticks(base + 1, 40);
    chk("div4_applied", cur_div_o, 4);
    exp_hi.push_back(4);
    en_i = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && busy_o; i++) begin step(); n++; end
    chk("drain_len", n, 4);
    chk("drain_clk", clk_o, 0);
    step();
    chk("stop_hold_clk", clk_o, 0);
    exp_hi.push_back(4); exp_hi.push_back(4);
    exp_per.push_back(8); exp_per.push_back(8);
    en_i = 1'b1;
    base = ticks;
    wait_ticks(base + 3, 60);
    chk("per_q_empty", exp_per.size(), 0);
    chk("hi_q_empty", exp_hi.size(), 0);

    // Reset mid-high-phase with a ratio pending
    div_i = 7; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    chk("pre_rst_pend", div_ready_o, 0);
    rst_i = 1'b0;
    step();
    chk("mid_rst_clk", clk_o, 0);
    chk("mid_rst_ready", div_ready_o, 1);
    chk("mid_rst_cur_div", cur_div_o, DEF_DIV);
    chk("mid_rst_busy", busy_o, 0);
    rst_i = 1'b1;
    en_i = 1'b0;
    step();
    step();
    chk("rst_pend_dropped", cur_div_o, DEF_DIV);

    // Minimum ratio: clk_o toggles every cycle
    div_i = 1; div_valid_i = 1'b1;
    step();
    div_valid_i = 1'b0;
    step();
    chk("div1_applied", cur_div_o, 1);
    exp_per.push_back(2); exp_per.push_back(2);
    exp_hi.push_back(1); exp_hi.push_back(1);
    en_i = 1'b1;
    base = ticks;
    wait_ticks(base + 3, 40);
    en_i = 1'b0;
    repeat (4) step();
    chk("final_busy", busy_o, 0);
    chk("final_per_q", exp_per.size(), 0);
    chk("final_hi_q", exp_hi.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
